// File: rtl/mips_fetch_pkg.sv
// Shared types and defaults for the MIPS fetch stage: FSM state encoding,
// redirect-select encoding and memory-range defaults.
package mips_fetch_pkg;

  localparam int unsigned DEFAULT_RESET_PC   = 0;
  localparam int unsigned DEFAULT_IMEM_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JR     = 2'd3
  } redirect_sel_t;

  // Redirect priority: jr > jump > branch > sequential.
  function automatic redirect_sel_t select_redirect(input logic jr,
                                                    input logic jump,
                                                    input logic branch_taken);
    if (jr)                return SEL_JR;
    else if (jump)         return SEL_JUMP;
    else if (branch_taken) return SEL_BRANCH;
    else                   return SEL_SEQ;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage, with a range check
// applied to the wrapped result.
module next_pc_calc
  import mips_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
  input  logic [PC_WIDTH-1:0] instr_pc,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_target,
  input  logic                jr,
  input  logic [PC_WIDTH-1:0] jr_target,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                out_of_range
);

  logic [PC_WIDTH-1:0] seq_pc;
  redirect_sel_t       sel;

  assign seq_pc = instr_pc + PC_WIDTH'(1);
  assign sel    = select_redirect(jr, jump, branch_taken);

  always_comb begin
    next_pc = seq_pc;
    unique case (sel)
      SEL_JR:     next_pc = jr_target;
      SEL_JUMP:   next_pc = PC_WIDTH'(jump_target);
      SEL_BRANCH: next_pc = seq_pc + branch_offset;
      default:    next_pc = seq_pc;
    endcase
  end

  // Sums above already wrapped modulo 2^PC_WIDTH; compare the wrapped value.
  assign out_of_range = (32'(next_pc) >= 32'(IMEM_DEPTH));

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, captures instruction memory data and hands it to
// decode. Define FETCH_PERF_CNT_EN to build the fetch_count handshake counter.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned IMEM_DEPTH  = DEFAULT_IMEM_DEPTH,
  parameter int unsigned RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] instruction_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_offset,
  input  logic                   jump,
  input  logic [25:0]            jump_target,
  input  logic                   jr,
  input  logic [PC_WIDTH-1:0]    jr_target,
  output logic                   halt,
  output logic [31:0]            fetch_count
);

  fetch_state_t           state_reg, state_next;
  logic [PC_WIDTH-1:0]    pc_reg;
  logic [PC_WIDTH-1:0]    instr_pc_reg;
  logic [INSTR_WIDTH-1:0] instr_out_reg;
  logic [PC_WIDTH-1:0]    next_pc;
  logic                   out_of_range;
  logic                   handshake;

  next_pc_calc #(
    .PC_WIDTH   (PC_WIDTH),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_next_pc_calc (
    .instr_pc      (instr_pc_reg),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .next_pc       (next_pc),
    .out_of_range  (out_of_range)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_ISSUE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  state_next = ST_VALID;
      ST_VALID: if (instr_ready) state_next = out_of_range ? ST_HALT : ST_ISSUE;
      default:  state_next = ST_HALT;
    endcase
  end

  always_comb begin
    instr_valid = (state_reg == ST_VALID);
    halt        = (state_reg == ST_HALT);
  end

  assign handshake = instr_valid && instr_ready;

  // The out-of-range PC is still loaded on the halting handshake, then frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg        <= PC_WIDTH'(RESET_PC);
      instr_pc_reg  <= '0;
      instr_out_reg <= '0;
    end else begin
      if (state_reg == ST_WAIT) begin
        instr_out_reg <= instruction_in;
        instr_pc_reg  <= pc_reg;
      end
      if (handshake) pc_reg <= next_pc;
    end
  end

  assign pc        = pc_reg;
  assign instr_pc  = instr_pc_reg;
  assign instr_out = instr_out_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          fetch_count_reg <= '0;
    else if (handshake) fetch_count_reg <= fetch_count_reg + 32'd1;
  end

  assign fetch_count = fetch_count_reg;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a one-cycle-latency instruction
// memory model holding word k = 32'h1000_0000 + k.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [31:0] instruction_in;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [15:0] jr_target;
  logic        halt;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .instruction_in (instruction_in),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_target    (jump_target),
    .jr             (jr),
    .jr_target      (jr_target),
    .halt           (halt),
    .fetch_count    (fetch_count)
  );

  // Synchronous-read instruction memory: data for pc appears after one edge.
  always @(posedge clk) instruction_in <= 32'h1000_0000 + 32'(pc);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic wait_valid(input int max_cycles);
    int cycles = 0;
    while (!instr_valid && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
    end
    check("valid_within_budget", 64'(instr_valid), 64'd1);
  endtask

  // Called at a negedge with instr_valid high: present redirects, let one
  // handshake edge pass, clear the redirects.
  task automatic step(input logic s_jr, input logic [15:0] s_jrt,
                      input logic s_jump, input logic [25:0] s_jt,
                      input logic s_br, input logic [15:0] s_off);
    jr = s_jr; jr_target = s_jrt;
    jump = s_jump; jump_target = s_jt;
    branch_taken = s_br; branch_offset = s_off;
    instr_ready = 1'b1;
    @(negedge clk);
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jr_target = '0; jump_target = '0; branch_offset = '0;
  endtask

  task automatic expect_instr(input string tag, input logic [15:0] exp_pc);
    check({tag, "_pc"}, 64'(instr_pc), 64'(exp_pc));
    check({tag, "_data"}, 64'(instr_out), 64'(32'h1000_0000 + 32'(exp_pc)));
  endtask

  initial begin
    logic [31:0] exp_cnt;
    reset = 1'b1; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_offset = '0;
    jump = 1'b0; jump_target = '0; jr = 1'b0; jr_target = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_instr_out", 64'(instr_out), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_fetch_count", 64'(fetch_count), 64'd0);

    // First fetch: valid after the 2nd rising edge.
    instr_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("lat_edge1_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    check("lat_edge2_valid", 64'(instr_valid), 64'd1);
    expect_instr("first", 16'd0);

    // Back-to-back sequential fetches, 3 cycles apart.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("seq_gap_valid", 64'(instr_valid), 64'd0);
      repeat (2) @(negedge clk);
      check("seq_valid", 64'(instr_valid), 64'd1);
      expect_instr("seq", 16'(k));
    end

    // Stall: instr_ready low for 5 cycles holds everything.
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(instr_valid), 64'd1);
      check("stall_pc", 64'(pc), 64'd3);
      expect_instr("stall", 16'd3);
    end

    // Move to 10, then branch -4 -> 7.
    step(1'b1, 16'd10, 1'b0, 26'd0, 1'b0, 16'd0);
    wait_valid(10);
    expect_instr("jr10", 16'd10);
    step(1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 16'hFFFC);
    wait_valid(10);
    expect_instr("br_minus4", 16'd7);

    // Back to 10, branch +5 -> 16.
    step(1'b1, 16'd10, 1'b0, 26'd0, 1'b0, 16'd0);
    wait_valid(10);
    step(1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 16'd5);
    wait_valid(10);
    expect_instr("br_plus5", 16'd16);

    // All redirects together: jr wins.
    step(1'b1, 16'd40, 1'b1, 26'd20, 1'b1, 16'd3);
    wait_valid(10);
    expect_instr("prio_jr", 16'd40);
    // Jump beats branch.
    step(1'b0, 16'd0, 1'b1, 26'd20, 1'b1, 16'd3);
    wait_valid(10);
    expect_instr("prio_jump", 16'd20);
    // Redirects ignored while not handshaking.
    instr_ready = 1'b0;
    jr = 1'b1; jr_target = 16'd99;
    @(negedge clk);
    jr = 1'b0; jr_target = '0;
    step(1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 16'd0);
    wait_valid(10);
    expect_instr("seq_after_ignored", 16'd21);

    // jr out of range -> HALT with pc frozen at 256.
    step(1'b1, 16'd256, 1'b0, 26'd0, 1'b0, 16'd0);
    check("halt_jr", 64'(halt), 64'd1);
    check("halt_jr_valid", 64'(instr_valid), 64'd0);
    check("halt_jr_pc", 64'(pc), 64'd256);
    repeat (3) @(negedge clk);
    check("halt_hold", 64'(halt), 64'd1);
    check("halt_hold_pc", 64'(pc), 64'd256);
    check("halt_hold_valid", 64'(instr_valid), 64'd0);

    reset = 1'b1;
    #1;
    check("halt_rst_pc", 64'(pc), 64'd0);
    check("halt_rst_halt", 64'(halt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(10);
    expect_instr("after_halt_rst", 16'd0);

    // Sequential step from 255 wraps out of range -> HALT.
    step(1'b1, 16'd255, 1'b0, 26'd0, 1'b0, 16'd0);
    wait_valid(10);
    expect_instr("at255", 16'd255);
    step(1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 16'd0);
    check("halt_seq", 64'(halt), 64'd1);
    check("halt_seq_pc", 64'(pc), 64'd256);

    // Reset pulse while in WAIT.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_valid(10);
    step(1'b1, 16'd50, 1'b0, 26'd0, 1'b0, 16'd0);
    @(negedge clk);
    check("wait_pre_pc", 64'(pc), 64'd50);
    reset = 1'b1;
    #1;
    check("wait_rst_pc", 64'(pc), 64'd0);
    check("wait_rst_valid", 64'(instr_valid), 64'd0);
    repeat (2) @(negedge clk);
    check("wait_rst_hold_valid", 64'(instr_valid), 64'd0);
    reset = 1'b0;
    wait_valid(10);
    expect_instr("wait_rst_refetch", 16'd0);
    check("cnt_after_rst", 64'(fetch_count), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 16'd0);
      wait_valid(10);
    end
    expect_instr("four_steps", 16'd4);
`ifdef FETCH_PERF_CNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    check("cnt_after_4", 64'(fetch_count), 64'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
